encoder_bank_ctrl: RTL and testbench

Configuration and bank-swap controller for the two-entry encoder generator RAM. Accepts new 16-bit generator-tap words over a valid/ready handshake and writes each one into the shadow bank. At the next frame boundary it commits the word by swapping the two read banks in two skewed phases. The low-order-tap read address (`raddr1`) switches first; the high-order-tap read address (`raddr0`) switches `SKEW` cycles later, matching the encoder pipeline. It sits between the configuration register interface and the encoder RAM write/read-address ports.

---
 rtl/encoder_pkg.sv | 14 +
 rtl/encoder_bank_ctrl.sv | 117 +++++++++++
 tb/tb_encoder_bank_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and widths for the encoder bank controller
package encoder_pkg;

    localparam int SKEW_CNT_W = 4;
    localparam int GEN_WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_PENDING = 2'd2,
        ST_SKEW    = 2'd3
    } bank_state_t;

endpackage

// File: rtl/encoder_bank_ctrl.sv
// rtl/encoder_bank_ctrl.sv - generator RAM shadow-write and skewed bank-swap controller
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_valid/cfg_ready     generator word handshake, cfg_data carries the word
//   frame_start             frame-boundary pulse that commits a pending word
//   we, waddr, din          registered RAM write port (shadow bank)
//   raddr0, raddr1          registered read banks for high / low order taps
//   pending                 a written word waits for frame_start
//   swap_done               one-cycle pulse when raddr0 completes the swap
module encoder_bank_ctrl
    import encoder_pkg::*;
#(
    parameter int unsigned SKEW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [GEN_WORD_W-1:0] cfg_data,
    input  logic                  frame_start,
    output logic                  we,
    output logic                  waddr,
    output logic [GEN_WORD_W-1:0] din,
    output logic                  raddr0,
    output logic                  raddr1,
    output logic                  pending,
    output logic                  swap_done
);

    // The counter starts at SKEW-1 on the raddr1 toggle so that raddr0
    // toggles exactly SKEW edges later; SKEW=0 never uses it.
    localparam logic [SKEW_CNT_W-1:0] SKEW_LOAD =
        (SKEW == 0) ? '0 : SKEW_CNT_W'(SKEW - 1);

    bank_state_t           state, state_n;
    logic [SKEW_CNT_W-1:0] cnt, cnt_n;
    logic                  we_n, waddr_n, raddr0_n, raddr1_n, swap_done_n;
    logic [GEN_WORD_W-1:0] din_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we        <= 1'b0;
            waddr     <= 1'b0;
            din       <= '0;
            raddr0    <= 1'b0;
            raddr1    <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            we        <= we_n;
            waddr     <= waddr_n;
            din       <= din_n;
            raddr0    <= raddr0_n;
            raddr1    <= raddr1_n;
            swap_done <= swap_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        we_n        = 1'b0;
        waddr_n     = waddr;
        din_n       = din;
        raddr0_n    = raddr0;
        raddr1_n    = raddr1;
        swap_done_n = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    // raddr0 == raddr1 here, so ~raddr0 is the shadow bank.
                    din_n   = cfg_data;
                    waddr_n = ~raddr0;
                    we_n    = 1'b1;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A frame_start coinciding with the write is deliberately dropped.
                state_n = ST_PENDING;
            end
            ST_PENDING: begin
                if (frame_start) begin
                    raddr1_n = ~raddr1;
                    if (SKEW == 0) begin
                        raddr0_n    = ~raddr0;
                        swap_done_n = 1'b1;
                        state_n     = ST_IDLE;
                    end else begin
                        cnt_n   = SKEW_LOAD;
                        state_n = ST_SKEW;
                    end
                end
            end
            ST_SKEW: begin
                if (cnt == '0) begin
                    raddr0_n    = ~raddr0;
                    swap_done_n = 1'b1;
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Ready is gated by rst_n so no word is offered acceptance during reset.
    assign cfg_ready = rst_n && (state == ST_IDLE);
    assign pending   = (state == ST_PENDING);

endmodule

// File: tb/tb_encoder_bank_ctrl.sv
// tb/tb_encoder_bank_ctrl.sv - self-checking bench for encoder_bank_ctrl
module tb_encoder_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = '0;
    logic        frame_start = 1'b0;

    logic        a_cfg_ready, a_we, a_waddr, a_raddr0, a_raddr1, a_pending, a_swap_done;
    logic [15:0] a_din;
    logic        b_cfg_ready, b_we, b_waddr, b_raddr0, b_raddr1, b_pending, b_swap_done;
    logic [15:0] b_din;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    encoder_bank_ctrl #(.SKEW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_data(cfg_data), .frame_start(frame_start), .we(a_we), .waddr(a_waddr),
        .din(a_din), .raddr0(a_raddr0), .raddr1(a_raddr1), .pending(a_pending),
        .swap_done(a_swap_done)
    );

    encoder_bank_ctrl #(.SKEW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_data(cfg_data), .frame_start(frame_start), .we(b_we), .waddr(b_waddr),
        .din(b_din), .raddr0(b_raddr0), .raddr1(b_raddr1), .pending(b_pending),
        .swap_done(b_swap_done)
    );

    // Timestamp reference model: a transaction is described by the edge it was
    // accepted at, the edge its frame_start was taken at, and the committed bank.
    int          m_skew [2] = '{4, 0};
    bit          m_busy [2];
    bit          m_bank [2];
    int          m_acc  [2];
    int          m_fs   [2];
    int          m_done [2];
    bit          m_waddr[2];
    logic [15:0] m_din  [2];

    task automatic model_step(input int u);
        if (!rst_n) begin
            m_busy[u] = 0; m_bank[u] = 0; m_acc[u] = -10; m_fs[u] = -1;
            m_done[u] = -10; m_waddr[u] = 0; m_din[u] = '0;
        end else if (!m_busy[u]) begin
            if (cfg_valid) begin
                m_busy[u] = 1; m_acc[u] = cyc; m_fs[u] = -1;
                m_waddr[u] = ~m_bank[u]; m_din[u] = cfg_data;
            end
        end else begin
            if (m_fs[u] < 0 && frame_start && cyc >= m_acc[u] + 2) m_fs[u] = cyc;
            if (m_fs[u] >= 0 && cyc == m_fs[u] + m_skew[u]) begin
                m_bank[u] = ~m_bank[u]; m_busy[u] = 0; m_done[u] = cyc;
            end
        end
    endtask

    function automatic logic [22:0] model_outputs(input int u);
        logic rdy, wev, pend, r1, sd;
        rdy  = rst_n && !m_busy[u];
        wev  = m_busy[u] && (cyc == m_acc[u]);
        pend = m_busy[u] && (m_fs[u] < 0) && (cyc > m_acc[u]);
        r1   = m_bank[u] ^ (m_busy[u] && m_fs[u] >= 0);
        sd   = (cyc == m_done[u]);
        return {rdy, wev, m_waddr[u], m_din[u], m_bank[u], r1, pend, sd};
    endfunction

    task automatic tick(input logic rn, input logic v, input logic fs, input logic [15:0] d);
        rst_n = rn; cfg_valid = v; frame_start = fs; cfg_data = d;
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset;
        tick(0, 0, 0, 16'h0);
        tick(0, 1, 1, 16'hFFFF);
        n_checks++; if (a_cfg_ready !== 1'b0) $display("FAIL rst_ready_low: got %b want 0", a_cfg_ready); else n_pass++;
        n_checks++; if ({a_raddr0, a_raddr1} !== 2'b00) $display("FAIL rst_raddr: got %b want 00", {a_raddr0, a_raddr1}); else n_pass++;
        n_checks++; if ({a_we, a_waddr, a_pending, a_swap_done} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {a_we, a_waddr, a_pending, a_swap_done}); else n_pass++;
        n_checks++; if (a_din !== 16'h0) $display("FAIL rst_din: got %h want 0000", a_din); else n_pass++;
        tick(1, 0, 0, 16'h0);
        n_checks++; if (a_cfg_ready !== 1'b1) $display("FAIL rst_ready_idle: got %b want 1", a_cfg_ready); else n_pass++;
    endtask

    task automatic test_write;
        tick(1, 1, 0, 16'hA5C3);
        n_checks++; if ({a_we, a_waddr} !== 2'b11) $display("FAIL wr_we_waddr: got %b want 11", {a_we, a_waddr}); else n_pass++;
        n_checks++; if (a_din !== 16'hA5C3) $display("FAIL wr_din: got %h want a5c3", a_din); else n_pass++;
        n_checks++; if (a_cfg_ready !== 1'b0) $display("FAIL wr_ready: got %b want 0", a_cfg_ready); else n_pass++;
        tick(1, 0, 0, 16'h0);
        n_checks++; if ({a_we, a_pending} !== 2'b01) $display("FAIL wr_pending: got %b want 01", {a_we, a_pending}); else n_pass++;
        n_checks++; if ({a_raddr0, a_raddr1} !== 2'b00) $display("FAIL wr_raddr: got %b want 00", {a_raddr0, a_raddr1}); else n_pass++;
        tick(1, 0, 0, 16'h0);
        n_checks++; if ({a_we, a_pending} !== 2'b01) $display("FAIL wr_we_once: got %b want 01", {a_we, a_pending}); else n_pass++;
    endtask

    task automatic test_swap_skew;
        tick(1, 0, 1, 16'h0);
        n_checks++; if ({a_raddr1, a_raddr0, a_pending} !== 3'b100) $display("FAIL sw_first: got %b want 100", {a_raddr1, a_raddr0, a_pending}); else n_pass++;
        n_checks++; if ({b_raddr1, b_raddr0, b_swap_done} !== 3'b111) $display("FAIL sw_skew0: got %b want 111", {b_raddr1, b_raddr0, b_swap_done}); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            tick(1, 0, 0, 16'h0);
            n_checks++;
            if ({a_raddr0, a_swap_done, a_cfg_ready, a_raddr1} !== {{3{i == 4}}, 1'b1})
                $display("FAIL sw_step%0d: got %b want %b", i, {a_raddr0, a_swap_done, a_cfg_ready, a_raddr1}, {{3{i == 4}}, 1'b1});
            else n_pass++;
            if (i == 1) begin
                n_checks++; if ({b_swap_done, b_cfg_ready} !== 2'b01) $display("FAIL sw_skew0_once: got %b want 01", {b_swap_done, b_cfg_ready}); else n_pass++;
            end
        end
        tick(1, 0, 0, 16'h0);
        n_checks++; if (a_swap_done !== 1'b0) $display("FAIL sw_pulse_width: got %b want 0", a_swap_done); else n_pass++;
    endtask

    task automatic test_ignored_pulses;
        int dones = 0;
        tick(1, 1, 0, 16'h1234);
        n_checks++; if ({a_we, a_waddr} !== 2'b10) $display("FAIL ig_waddr: got %b want 10", {a_we, a_waddr}); else n_pass++;
        tick(1, 0, 1, 16'h0);
        n_checks++; if ({a_raddr1, a_pending} !== 2'b11) $display("FAIL ig_write_pulse: got %b want 11", {a_raddr1, a_pending}); else n_pass++;
        tick(1, 0, 1, 16'h0);
        n_checks++; if ({a_raddr1, a_raddr0} !== 2'b01) $display("FAIL ig_fire: got %b want 01", {a_raddr1, a_raddr0}); else n_pass++;
        tick(1, 0, 1, 16'h0);
        n_checks++; if ({a_raddr1, a_raddr0} !== 2'b01) $display("FAIL ig_skew_pulse: got %b want 01", {a_raddr1, a_raddr0}); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, (i == 1), 16'h0);
            dones += a_swap_done;
        end
        n_checks++; if (dones !== 1) $display("FAIL ig_done_count: got %0d want 1", dones); else n_pass++;
        n_checks++; if ({a_raddr1, a_raddr0} !== 2'b00) $display("FAIL ig_final: got %b want 00", {a_raddr1, a_raddr0}); else n_pass++;
    endtask

    task automatic test_held_valid;
        int writes = 0;
        tick(1, 1, 0, 16'h1111);
        n_checks++; if ({a_we, a_waddr, a_din} !== {2'b11, 16'h1111}) $display("FAIL hv_first: got %b %h want 11 1111", {a_we, a_waddr}, a_din); else n_pass++;
        tick(1, 1, 0, 16'h2222); writes += a_we;
        tick(1, 1, 0, 16'h2222); writes += a_we;
        tick(1, 1, 1, 16'h2222); writes += a_we;
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 0, 16'h2222); writes += a_we;
        end
        n_checks++; if (writes !== 0 || a_cfg_ready !== 1'b1) $display("FAIL hv_no_rewrite: got writes=%0d ready=%b want 0 1", writes, a_cfg_ready); else n_pass++;
        tick(1, 1, 0, 16'h2222);
        n_checks++; if ({a_we, a_waddr, a_din} !== {2'b10, 16'h2222}) $display("FAIL hv_reaccept: got %b %h want 10 2222", {a_we, a_waddr}, a_din); else n_pass++;
    endtask

    task automatic test_reset_mid_skew;
        int dones = 0;
        tick(1, 0, 0, 16'h0);
        tick(1, 0, 1, 16'h0);
        tick(1, 0, 0, 16'h0);
        n_checks++; if ({a_raddr1, a_raddr0} !== 2'b01) $display("FAIL rm_in_skew: got %b want 01", {a_raddr1, a_raddr0}); else n_pass++;
        tick(0, 0, 0, 16'h0);
        n_checks++; if ({a_raddr1, a_raddr0, a_swap_done, a_cfg_ready} !== 4'b0) $display("FAIL rm_cleared: got %b want 0000", {a_raddr1, a_raddr0, a_swap_done, a_cfg_ready}); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, 0, 16'h0);
            dones += a_swap_done;
        end
        n_checks++; if (dones !== 0 || a_cfg_ready !== 1'b1 || a_raddr0 !== 1'b0) $display("FAIL rm_after: got done=%0d ready=%b raddr0=%b want 0 1 0", dones, a_cfg_ready, a_raddr0); else n_pass++;
    endtask

    task automatic test_random;
        logic [22:0] exp_a, exp_b;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0), 16'($urandom));
            exp_a = model_outputs(0);
            exp_b = model_outputs(1);
            n_checks++;
            if ({a_cfg_ready, a_we, a_waddr, a_din, a_raddr0, a_raddr1, a_pending, a_swap_done} !== exp_a)
                $display("FAIL rnd_skew4 cyc%0d: got %h want %h", cyc,
                         {a_cfg_ready, a_we, a_waddr, a_din, a_raddr0, a_raddr1, a_pending, a_swap_done}, exp_a);
            else n_pass++;
            n_checks++;
            if ({b_cfg_ready, b_we, b_waddr, b_din, b_raddr0, b_raddr1, b_pending, b_swap_done} !== exp_b)
                $display("FAIL rnd_skew0 cyc%0d: got %h want %h", cyc,
                         {b_cfg_ready, b_we, b_waddr, b_din, b_raddr0, b_raddr1, b_pending, b_swap_done}, exp_b);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_swap_skew;
        test_ignored_pulses;
        test_held_valid;
        test_reset_mid_skew;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
